// File: rtl/nes_joypad_pkg.sv
// rtl/nes_joypad_pkg.sv - button indices, button word type and SOCD helper for the joypad port
package nes_joypad_pkg;

  typedef logic [7:0] joy_buttons_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Opposing directions pressed together cancel out instead of reaching the game.
  function automatic joy_buttons_t socd_clean(input joy_buttons_t b);
    joy_buttons_t r;
    r = b;
    if (b[BTN_UP] && b[BTN_DOWN]) begin
      r[BTN_UP]   = 1'b0;
      r[BTN_DOWN] = 1'b0;
    end
    if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
      r[BTN_LEFT]  = 1'b0;
      r[BTN_RIGHT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/nes_joypad_if.sv
// rtl/nes_joypad_if.sv - controller bus between the NES core (master) and the joypad port (slave)
interface nes_joypad_if;

  logic       joy_strobe;
  logic [1:0] joy_clock;
  logic [1:0] joy_data;

  modport master (
    output joy_strobe,
    output joy_clock,
    input  joy_data
  );

  modport slave (
    input  joy_strobe,
    input  joy_clock,
    output joy_data
  );

endinterface

// File: rtl/joypad_shifter.sv
// rtl/joypad_shifter.sv - per-player sticky press register plus parallel-load / serial-out shift register
module joypad_shifter
  import nes_joypad_pkg::*;
#(
  parameter bit FILL_BIT = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  joy_buttons_t btn_sync,
  input  logic         strobe,
  input  logic         strobe_fall,
  input  logic         clock_fall,
  input  joy_buttons_t load_word,
  output joy_buttons_t raw_word,
  output logic         data
);

  joy_buttons_t sticky;
  joy_buttons_t shreg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky <= '0;
      shreg  <= '0;
    end else begin
      if (strobe_fall) begin
        sticky <= btn_sync;
      end else begin
        sticky <= sticky | btn_sync;
      end

      // A read clock edge while strobe is high is dropped: the reload wins.
      if (strobe) begin
        shreg <= load_word;
      end else if (clock_fall) begin
        shreg <= {FILL_BIT, shreg[7:1]};
      end
    end
  end

  assign raw_word = sticky | btn_sync;
  assign data     = shreg[0];

endmodule

// File: rtl/nes_joypad_port.sv
// rtl/nes_joypad_port.sv - two-player NES controller port: sync, SOCD, optional turbo (JOYPAD_TURBO_EN)
module nes_joypad_port
  import nes_joypad_pkg::*;
#(
  parameter int CLK_HZ      = 21428571,
  parameter int TURBO_HZ    = 10,
  parameter int SYNC_STAGES = 2,
  parameter bit FILL_BIT    = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  joy_buttons_t btn_p1,
  input  joy_buttons_t btn_p2,
  input  logic [1:0]   turbo_p1,
  input  logic [1:0]   turbo_p2,
  nes_joypad_if.slave  joy
);

  localparam int STAGES     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TURBO_HALF = CLK_HZ / (2 * TURBO_HZ);

  logic [15:0] sync_q [STAGES];
  logic        strobe_q;
  logic [1:0]  clock_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
      strobe_q <= 1'b0;
      clock_q  <= 2'b00;
    end else begin
      sync_q[0] <= {btn_p2, btn_p1};
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      strobe_q <= joy.joy_strobe;
      clock_q  <= joy.joy_clock;
    end
  end

  joy_buttons_t btn_sync_p1;
  joy_buttons_t btn_sync_p2;
  logic         strobe_fall;
  logic [1:0]   clock_fall;

  assign btn_sync_p1 = sync_q[STAGES-1][7:0];
  assign btn_sync_p2 = sync_q[STAGES-1][15:8];
  assign strobe_fall = strobe_q & ~joy.joy_strobe;
  assign clock_fall  = clock_q & ~joy.joy_clock;

  joy_buttons_t raw_p1, raw_p2;
  joy_buttons_t clean_p1, clean_p2;
  joy_buttons_t load_p1, load_p2;

  assign clean_p1 = socd_clean(raw_p1);
  assign clean_p2 = socd_clean(raw_p2);

`ifdef JOYPAD_TURBO_EN
  localparam int CNT_W = (TURBO_HALF > 1) ? $clog2(TURBO_HALF) : 1;

  logic [CNT_W-1:0] turbo_cnt;
  logic             turbo_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b0;
    end else if (turbo_cnt == CNT_W'(TURBO_HALF - 1)) begin
      turbo_cnt   <= '0;
      turbo_phase <= ~turbo_phase;
    end else begin
      turbo_cnt <= turbo_cnt + 1'b1;
    end
  end

  function automatic joy_buttons_t turbo_mask(input joy_buttons_t w, input logic [1:0] en,
                                              input logic phase);
    joy_buttons_t r;
    r = w;
    if (en[0]) r[BTN_A] = w[BTN_A] & phase;
    if (en[1]) r[BTN_B] = w[BTN_B] & phase;
    return r;
  endfunction

  assign load_p1 = turbo_mask(clean_p1, turbo_p1, turbo_phase);
  assign load_p2 = turbo_mask(clean_p2, turbo_p2, turbo_phase);
`else
  logic unused_turbo;

  assign unused_turbo = ^{turbo_p1, turbo_p2, TURBO_HALF[0]};
  assign load_p1      = clean_p1;
  assign load_p2      = clean_p2;
`endif

  logic data_p1, data_p2;

  joypad_shifter #(.FILL_BIT(FILL_BIT)) u_shifter_p1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_sync    (btn_sync_p1),
    .strobe      (joy.joy_strobe),
    .strobe_fall (strobe_fall),
    .clock_fall  (clock_fall[0]),
    .load_word   (load_p1),
    .raw_word    (raw_p1),
    .data        (data_p1)
  );

  joypad_shifter #(.FILL_BIT(FILL_BIT)) u_shifter_p2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_sync    (btn_sync_p2),
    .strobe      (joy.joy_strobe),
    .strobe_fall (strobe_fall),
    .clock_fall  (clock_fall[1]),
    .load_word   (load_p2),
    .raw_word    (raw_p2),
    .data        (data_p2)
  );

  assign joy.joy_data = {data_p2, data_p1};

endmodule

// File: tb/tb_nes_joypad_port.sv
// tb/tb_nes_joypad_port.sv - randomized self-checking bench for nes_joypad_port against a press-accumulation model
module tb_nes_joypad_port;

  logic       clk;
  logic       reset_n;
  logic [7:0] btn_p1, btn_p2;
  logic [1:0] turbo_p1, turbo_p2;
  int         checks;
  int         errors;
  logic [7:0] acc [2];

  nes_joypad_if joy ();

  nes_joypad_port #(
    .CLK_HZ      (1000),
    .TURBO_HZ    (10),
    .SYNC_STAGES (2),
    .FILL_BIT    (1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_p1   (btn_p1),
    .btn_p2   (btn_p2),
    .turbo_p1 (turbo_p1),
    .turbo_p2 (turbo_p2),
    .joy      (joy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: everything pressed since the last latch is reported, minus opposing directions.
  function automatic logic [7:0] expect_word(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[4] && v[5]) r = r & 8'hCF;
    if (v[6] && v[7]) r = r & 8'h3F;
    return r;
  endfunction

  task automatic set_btn(input logic [7:0] a, input logic [7:0] b);
    btn_p1 = a;
    btn_p2 = b;
    acc[0] = acc[0] | a;
    acc[1] = acc[1] | b;
  endtask

  task automatic latch(output logic [7:0] e1, output logic [7:0] e2);
    e1 = expect_word(acc[0]);
    e2 = expect_word(acc[1]);
    joy.joy_strobe = 1'b1;
    step(2);
    joy.joy_strobe = 1'b0;
    acc[0] = btn_p1;
    acc[1] = btn_p2;
    step(1);
  endtask

  task automatic shift_out(output logic [7:0] w1, output logic [7:0] w2, output logic [1:0] fill);
    for (int i = 0; i < 8; i++) begin
      w1[i] = joy.joy_data[0];
      w2[i] = joy.joy_data[1];
      joy.joy_clock = 2'b11;
      step(1);
      joy.joy_clock = 2'b00;
      step(1);
    end
    fill = joy.joy_data;
  endtask

  task automatic read_both(output logic [7:0] w1, output logic [7:0] w2, output logic [1:0] fill,
                           output logic [7:0] e1, output logic [7:0] e2);
    latch(e1, e2);
    shift_out(w1, w2, fill);
  endtask

  task automatic test_reset;
    step(3);
    checks++;
    if (joy.joy_data !== 2'b00) begin
      errors++;
      $display("FAIL reset_data got %b want 00", joy.joy_data);
    end
    reset_n = 1'b1;
    acc[0] = 8'h00;
    acc[1] = 8'h00;
    step(3);
    checks++;
    if (joy.joy_data !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_data got %b want 00", joy.joy_data);
    end
  endtask

  task automatic test_basic_read;
    logic [7:0] w1, w2, e1, e2;
    logic [1:0] fill;
    set_btn(8'h09, 8'h00);
    step(4);
    read_both(w1, w2, fill, e1, e2);
    checks++;
    if (w1 !== 8'h09 || w1 !== e1) begin
      errors++;
      $display("FAIL basic_p1 got %h want %h", w1, e1);
    end
    checks++;
    if (w2 !== e2) begin
      errors++;
      $display("FAIL basic_p2 got %h want %h", w2, e2);
    end
    checks++;
    if (fill !== 2'b11) begin
      errors++;
      $display("FAIL basic_fill9 got %b want 11", fill);
    end
    for (int k = 0; k < 3; k++) begin
      joy.joy_clock = 2'b11;
      step(1);
      joy.joy_clock = 2'b00;
      step(1);
      checks++;
      if (joy.joy_data !== 2'b11) begin
        errors++;
        $display("FAIL basic_fill_extra%0d got %b want 11", k, joy.joy_data);
      end
    end
  endtask

  task automatic test_sticky;
    logic [7:0] w1, w2, e1, e2;
    logic [1:0] fill;
    set_btn(8'h00, 8'h00);
    step(4);
    read_both(w1, w2, fill, e1, e2);
    set_btn(8'h01, 8'h00);
    step(3);
    set_btn(8'h00, 8'h00);
    step(6);
    read_both(w1, w2, fill, e1, e2);
    checks++;
    if (w1 !== e1 || w1 !== 8'h01) begin
      errors++;
      $display("FAIL sticky_first got %h want %h", w1, e1);
    end
    read_both(w1, w2, fill, e1, e2);
    checks++;
    if (w1 !== e1 || w1 !== 8'h00) begin
      errors++;
      $display("FAIL sticky_second got %h want %h", w1, e1);
    end
  endtask

  task automatic test_socd;
    logic [7:0] w1, w2, e1, e2;
    logic [1:0] fill;
    logic [7:0] pats [2];
    pats[0] = 8'h30;
    pats[1] = 8'hC0;
    for (int k = 0; k < 2; k++) begin
      set_btn(8'h00, pats[k]);
      step(4);
      read_both(w1, w2, fill, e1, e2);
      checks++;
      if (w2 !== 8'h00 || e2 !== 8'h00) begin
        errors++;
        $display("FAIL socd_%0d got %h want 00", k, w2);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] w1, w2, e1, e2;
    logic [1:0] fill;
    for (int k = 0; k < 12; k++) begin
`ifndef JOYPAD_TURBO_EN
      turbo_p1 = 2'($urandom);
      turbo_p2 = 2'($urandom);
`endif
      set_btn(8'($urandom), 8'($urandom));
      step(4);
      if ($urandom_range(0, 1) == 1) begin
        set_btn(8'($urandom), 8'($urandom));
        step(4);
      end
      read_both(w1, w2, fill, e1, e2);
      checks++;
      if (w1 !== e1 || w2 !== e2) begin
        errors++;
        $display("FAIL random_%0d got %h_%h want %h_%h", k, w2, w1, e2, e1);
      end
      checks++;
      if (fill !== 2'b11) begin
        errors++;
        $display("FAIL random_fill_%0d got %b want 11", k, fill);
      end
    end
    turbo_p1 = 2'b00;
    turbo_p2 = 2'b00;
  endtask

  task automatic test_strobe_hold;
    logic [7:0] w1, w2, e1, e2;
    logic [1:0] fill;
    set_btn(8'h5A, 8'hA5);
    step(4);
    joy.joy_strobe = 1'b1;
    step(2);
    for (int k = 0; k < 4; k++) begin
      joy.joy_clock = 2'b11;
      step(1);
      joy.joy_clock = 2'b00;
      step(1);
      checks++;
      if (joy.joy_data !== {acc[1][0], acc[0][0]}) begin
        errors++;
        $display("FAIL hold_%0d got %b want %b", k, joy.joy_data, {acc[1][0], acc[0][0]});
      end
    end
    set_btn(8'h5B, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      joy.joy_clock = 2'b11;
      step(1);
      joy.joy_clock = 2'b00;
      step(1);
    end
    checks++;
    if (joy.joy_data[0] !== 1'b1) begin
      errors++;
      $display("FAIL hold_live got %b want 1", joy.joy_data[0]);
    end
    e1 = expect_word(acc[0]);
    e2 = expect_word(acc[1]);
    joy.joy_strobe = 1'b0;
    acc[0] = btn_p1;
    acc[1] = btn_p2;
    step(1);
    shift_out(w1, w2, fill);
    checks++;
    if (w1 !== e1 || w2 !== e2) begin
      errors++;
      $display("FAIL hold_noshift got %h_%h want %h_%h", w2, w1, e2, e1);
    end
  endtask

  task automatic test_independent;
    logic [7:0] e1, e2;
    set_btn(8'h16, 8'h29);
    step(4);
    latch(e1, e2);
    for (int k = 0; k < 3; k++) begin
      joy.joy_clock = 2'b01;
      step(1);
      joy.joy_clock = 2'b00;
      step(1);
    end
    checks++;
    if (joy.joy_data !== {e2[0], e1[3]}) begin
      errors++;
      $display("FAIL indep_p1 got %b want %b", joy.joy_data, {e2[0], e1[3]});
    end
    for (int k = 0; k < 2; k++) begin
      joy.joy_clock = 2'b10;
      step(1);
      joy.joy_clock = 2'b00;
      step(1);
    end
    checks++;
    if (joy.joy_data !== {e2[2], e1[3]}) begin
      errors++;
      $display("FAIL indep_p2 got %b want %b", joy.joy_data, {e2[2], e1[3]});
    end
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] w1, w2, e1, e2;
    logic [1:0] fill;
    set_btn(8'hAD, 8'h6B);
    step(4);
    latch(e1, e2);
    for (int k = 0; k < 3; k++) begin
      joy.joy_clock = 2'b11;
      step(1);
      joy.joy_clock = 2'b00;
      step(1);
    end
    checks++;
    if (joy.joy_data !== {e2[3], e1[3]}) begin
      errors++;
      $display("FAIL midread_pre got %b want %b", joy.joy_data, {e2[3], e1[3]});
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (joy.joy_data !== 2'b00) begin
      errors++;
      $display("FAIL midread_reset got %b want 00", joy.joy_data);
    end
    step(2);
    reset_n = 1'b1;
    acc[0] = btn_p1;
    acc[1] = btn_p2;
    step(4);
    read_both(w1, w2, fill, e1, e2);
    checks++;
    if (w1 !== 8'hAD || w2 !== 8'h6B || w1 !== e1 || w2 !== e2) begin
      errors++;
      $display("FAIL midread_reload got %h_%h want %h_%h", w2, w1, e2, e1);
    end
  endtask

  task automatic test_turbo;
    logic v;
    int   waited;
    set_btn(8'h03, 8'h00);
    turbo_p1 = 2'b01;
    step(4);
    joy.joy_strobe = 1'b1;
    step(2);
`ifdef JOYPAD_TURBO_EN
    v = joy.joy_data[0];
    waited = 0;
    while (joy.joy_data[0] === v && waited < 200) begin
      step(1);
      waited++;
    end
    checks++;
    if (waited >= 200) begin
      errors++;
      $display("FAIL turbo_timeout got %0d want <200", waited);
    end else begin
      v = joy.joy_data[0];
      for (int j = 1; j <= 100; j++) begin
        step(1);
        checks++;
        if (joy.joy_data[0] !== (v ^ 1'((j / 50) % 2))) begin
          errors++;
          $display("FAIL turbo_cycle%0d got %b want %b", j, joy.joy_data[0], v ^ 1'((j / 50) % 2));
        end
      end
    end
`else
    v = 1'b1;
    waited = 0;
    for (int j = 0; j < 120; j++) begin
      step(1);
      if (joy.joy_data[0] !== v) waited++;
    end
    checks++;
    if (waited != 0) begin
      errors++;
      $display("FAIL turbo_ignored got %0d drops want 0", waited);
    end
`endif
    joy.joy_strobe = 1'b0;
    turbo_p1 = 2'b00;
    acc[0] = btn_p1;
    acc[1] = btn_p2;
    step(2);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    btn_p1         = 8'h00;
    btn_p2         = 8'h00;
    turbo_p1       = 2'b00;
    turbo_p2       = 2'b00;
    joy.joy_strobe = 1'b0;
    joy.joy_clock  = 2'b00;
    acc[0]         = 8'h00;
    acc[1]         = 8'h00;
    test_reset();
    test_basic_read();
    test_sticky();
    test_socd();
    test_random();
    test_strobe_hold();
    test_independent();
    test_reset_mid_read();
    test_turbo();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_joypad_port.md
NES_JOYPAD_PORT -- requirements
Module: nes_joypad_port

Interface
REQ-001 SHALL have parameter CLK_HZ, default 21428571, frequency of clk in Hz.
REQ-002 SHALL have parameter TURBO_HZ, default 10, turbo press rate in Hz.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for button inputs, minimum 2.
REQ-004 SHALL have parameter FILL_BIT, default 0, value shifted in after the 8th read.
REQ-005 SHALL have port clk, input, 1, NES system clock; the block uses this one clock only.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port btn_p1, input, 8, player-1 buttons, active-high, asynchronous to clk; bit order 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
REQ-008 SHALL have port btn_p2, input, 8, player-2 buttons, same encoding as btn_p1.
REQ-009 SHALL have port turbo_p1, input, 2, turbo enable for player-1 B (bit 1) and A (bit 0).
REQ-010 SHALL have port turbo_p2, input, 2, turbo enable for player-2, same encoding as turbo_p1.
REQ-011 SHALL have port joy_strobe, input, 1, controller latch from the NES core.
REQ-012 SHALL have port joy_clock, input, 2, per-port read clock from the NES core; bit 0 is player 1, bit 1 is player 2.
REQ-013 SHALL have port joy_data, output, 2, serial button bit, active-high; bit 0 is player 1, bit 1 is player 2.

Function
REQ-014 SHALL pass each btn bit through a SYNC_STAGES flop synchronizer before any other use.
REQ-015 SHALL keep a sticky register per player that ORs in the synchronized buttons every cycle, so that presses shorter than one frame are not lost.
REQ-016 SHALL set each sticky register to the current synchronized value on the joy_strobe falling edge.
REQ-017 SHALL compute the load word as: sticky OR synchronized, then SOCD cleanup, then turbo mask.
REQ-018 SOCD cleanup SHALL clear both Up and Down when both are set, and SHALL clear both Left and Right when both are set.
REQ-019 SHALL reload each shift register with its load word on every clk cycle while joy_strobe is 1.
REQ-020 While joy_strobe is 0, a 1-to-0 transition of joy_clock[n] SHALL shift register n right one bit, with FILL_BIT entering at bit 7.
REQ-021 joy_data[n] SHALL equal bit 0 of shift register n, registered, with no combinational path from any input.
REQ-022 A joy_clock falling edge in the same cycle as joy_strobe=1 SHALL be ignored; the reload takes priority.
REQ-023 After 8 shifts, joy_data[n] SHALL read FILL_BIT indefinitely until the next strobe.
REQ-024 Edge detection SHALL use the previous-cycle value of joy_clock and joy_strobe; the previous-value registers reset to 0.
REQ-025 Both players SHALL operate independently; simultaneous edges on both ports SHALL both be honoured in the same cycle.

Reset
REQ-026 Asserting reset_n low SHALL clear the synchronizers, sticky registers, shift registers, edge registers and turbo counter to 0, and joy_data SHALL be 2'b00.
REQ-027 Reset mid-read SHALL discard any partially shifted word; the first strobe after release SHALL reload normally.

Configuration
REQ-028 The macro JOYPAD_TURBO_EN SHALL control turbo support.
REQ-029 With JOYPAD_TURBO_EN defined:
- a counter of width clog2(CLK_HZ/(2*TURBO_HZ)) SHALL toggle a turbo phase bit every CLK_HZ/(2*TURBO_HZ) cycles;
- where a turbo bit is set, the matching A/B load bit SHALL be ANDed with the phase.
REQ-030 With JOYPAD_TURBO_EN undefined, no counter SHALL be built and turbo_p1/turbo_p2 SHALL be ignored; the ports remain present.

Structure
REQ-031 A shared package nes_joypad_pkg SHALL hold the button-index constants (BTN_A..BTN_RIGHT) and the typedef joy_buttons_t (8 bits).
REQ-032 One sub-module, joypad_shifter, SHALL implement the per-player sticky register, load and shift; it SHALL be instantiated twice.
REQ-033 The synchronizer, SOCD cleanup and turbo logic SHALL stay in the top of the block.

Verification
REQ-034 Set btn_p1=8'h09 and strobe: the 8 joy_clock falls SHALL give joy_data[0] = 1,0,0,1,0,0,0,0, and a 9th fall SHALL give FILL_BIT.
REQ-035 Pulse btn_p1 bit 0 high for 3 cycles between strobes: the next read SHALL give bit A=1, and the read after that SHALL give A=0.
REQ-036 Set btn_p2=8'h30 (Up+Down) and 8'hC0 (Left+Right): the read SHALL give 8'h00 in both cases.
REQ-037 Hold joy_strobe=1 while toggling joy_clock: joy_data SHALL stay at the live bit 0 and no shift SHALL occur.
REQ-038 With JOYPAD_TURBO_EN, CLK_HZ=1000, TURBO_HZ=10, btn_p1[0]=1 and turbo_p1[0]=1: A SHALL alternate every 50 cycles; without the macro, A SHALL stay at 1.
REQ-039 Assert reset_n low after 3 shifts: joy_data SHALL be 0 at once, and the next strobe SHALL reload the full word.
